shift_ctrl: RTL and testbench

- Sequencer sitting directly upstream of the universal 4-bit shift register.
- Accepts a shift request (data, amount, direction, mode) over a start/ready handshake.
- Drives the register's select and serial-in lines cycle by cycle (load, then N single-bit shifts), then presents the result with a one-cycle done pulse.
- Supplies multi-bit logical, rotate and arithmetic shifts to the CPU datapath.

---
 rtl/shift_ctrl_pkg.sv | 13 +
 rtl/shift_ctrl_univ_shift_reg.sv | 30 +++
 rtl/shift_ctrl.sv | 111 +++++++++++
 tb/tb_shift_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared state encoding, register select codes and shift mode codes for shift_ctrl.
package shift_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [1:0] S_HOLD  = 2'b00;
  localparam logic [1:0] S_RIGHT = 2'b01;
  localparam logic [1:0] S_LEFT  = 2'b10;
  localparam logic [1:0] S_LOAD  = 2'b11;

  localparam logic [1:0] M_LOGIC = 2'b00;
  localparam logic [1:0] M_ROT   = 2'b01;
  localparam logic [1:0] M_ARITH = 2'b10;
endpackage

// File: rtl/shift_ctrl_univ_shift_reg.sv
// Universal WIDTH-bit shift register: hold / right / left / parallel load, sync active-low clear.
module univ_shift_reg
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] p,
  input  logic             sir,
  input  logic             sil,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!clear_n) r_q <= '0;
    else begin
      case (s)
        S_RIGHT: r_q <= {sir, r_q[WIDTH-1:1]};
        S_LEFT:  r_q <= {r_q[WIDTH-2:0], sil};
        S_LOAD:  r_q <= p;
        default: r_q <= r_q;
      endcase
    end
  end

  assign q = r_q;
endmodule

// File: rtl/shift_ctrl.sv
// Multi-bit shift sequencer driving univ_shift_reg one bit per cycle.
// Optional carry-out flop enabled by defining SHIFT_CTRL_CARRY_EN.
module shift_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amount,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [1:0]       s,
  output logic             sir,
  output logic             sil,
  output logic [WIDTH-1:0] q,
  output logic             done,
  output logic             carry
);
  state_t           r_state, w_next;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_dir;
  logic [1:0]       r_mode;
  logic [AMT_W-1:0] w_amt_sat;

  assign w_amt_sat = (amount > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amount;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_dir   <= 1'b0;
      r_mode  <= M_LOGIC;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_data <= data;
        r_dir  <= dir;
        r_mode <= mode;
        r_cnt  <= w_amt_sat;
      end else if (r_state == SHIFT) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    w_next = (r_cnt != '0) ? SHIFT : DONE;
      SHIFT:   if (r_cnt == AMT_W'(1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    s     = S_HOLD;
    ready = 1'b0;
    done  = 1'b0;
    case (r_state)
      IDLE:    ready = 1'b1;
      LOAD:    s = S_LOAD;
      SHIFT:   s = r_dir ? S_LEFT : S_RIGHT;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Only the side matching the direction carries a fill bit; reserved mode falls through as logical.
  always_comb begin
    sir = 1'b0;
    sil = 1'b0;
    case (r_mode)
      M_ROT:   if (r_dir) sil = q[WIDTH-1]; else sir = q[0];
      M_ARITH: if (!r_dir) sir = q[WIDTH-1];
      default: ;
    endcase
  end

  univ_shift_reg #(.WIDTH(WIDTH)) u_reg (
    .clk     (clk),
    .clear_n (clear_n),
    .s       (s),
    .p       (r_data),
    .sir     (sir),
    .sil     (sil),
    .q       (q)
  );

`ifdef SHIFT_CTRL_CARRY_EN
  logic r_carry;

  always_ff @(posedge clk) begin
    if (!clear_n)              r_carry <= 1'b0;
    else if (r_state == LOAD)  r_carry <= 1'b0;
    else if (r_state == SHIFT) r_carry <= r_dir ? q[WIDTH-1] : q[0];
  end

  assign carry = r_carry;
`else
  assign carry = 1'b0;
`endif
endmodule

// File: tb/tb_shift_ctrl.sv
// Randomized and directed bench for shift_ctrl against an arithmetic shift model.
module tb_shift_ctrl;
  localparam int W = 4;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       start = 1'b0;
  logic       ready;
  logic [3:0] data = '0;
  logic [2:0] amount = '0;
  logic       dir = 1'b0;
  logic [1:0] mode = '0;
  logic [1:0] s;
  logic       sir, sil;
  logic [3:0] q;
  logic       done;
  logic       carry;

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] prev_q = '0;

  shift_ctrl #(.WIDTH(4), .AMT_W(3)) dut (
    .clk(clk), .clear_n(clear_n), .start(start), .ready(ready),
    .data(data), .amount(amount), .dir(dir), .mode(mode),
    .s(s), .sir(sir), .sil(sil), .q(q), .done(done), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] mdl_q(input logic [3:0] d, input int n, input logic dr, input logic [1:0] md);
    int dd, mask, res;
    dd = d; mask = 15;
    if (md == 2'b01)
      res = dr ? (((dd << n) | (dd >> (W - n))) & mask) : (((dd >> n) | (dd << (W - n))) & mask);
    else if (md == 2'b10 && !dr)
      res = (dd >> n) | (d[3] ? ((mask << (W - n)) & mask) : 0);
    else
      res = dr ? ((dd << n) & mask) : (dd >> n);
    return res[3:0];
  endfunction

  function automatic logic mdl_carry(input logic [3:0] d, input int n, input logic dr);
`ifdef SHIFT_CTRL_CARRY_EN
    if (n == 0) return 1'b0;
    return dr ? d[W - n] : d[n - 1];
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_req(input logic [3:0] d, input logic [2:0] amt, input logic dr,
                         input logic [1:0] md, input bit busy, input bit rst_mid);
    int n;
    logic [1:0] sx;
    logic [3:0] exp_q;
    n = (amt > 3'd4) ? 4 : int'(amt);
    exp_q = mdl_q(d, n, dr, md);
    @(negedge clk);
    chk("idle_ready", ready, 1);
    chk("idle_q_hold", q, prev_q);
    data = d; amount = amt; dir = dr; mode = md; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1)          sx = 2'b11;
      else if (k <= n + 1) sx = dr ? 2'b10 : 2'b01;
      else                 sx = 2'b00;
      chk("sel", s, sx);
      chk("done", done, (k == n + 2));
      if (k == n + 2) begin
        chk("result_q", q, exp_q);
        chk("carry", carry, mdl_carry(d, n, dr));
        chk("done_ready", ready, 0);
      end
      if (busy && k == 2) begin
        start = 1'b1; data = ~d; amount = 3'd0; dir = ~dr;
      end
      if (rst_mid && k == 2) begin
        clear_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clear_n = 1'b1;
        chk("rst_q", q, 0);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_sel", s, 0);
        chk("rst_carry", carry, 0);
        repeat (4) begin
          @(negedge clk);
          chk("no_done_after_rst", done, 0);
        end
        prev_q = '0;
        return;
      end
    end
    prev_q = exp_q;
  endtask

  initial begin
    clear_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_q", q, 0);
    chk("reset_ready", ready, 1);
    chk("reset_done", done, 0);
    chk("reset_sel", s, 0);
    chk("reset_sir", sir, 0);
    chk("reset_sil", sil, 0);
    chk("reset_carry", carry, 0);
    clear_n = 1'b1;

    run_req(4'b1010, 3'd1, 1'b0, 2'b00, 0, 0);
    run_req(4'b1001, 3'd1, 1'b1, 2'b01, 0, 0);
    run_req(4'b1000, 3'd2, 1'b0, 2'b10, 0, 0);
    run_req(4'b1010, 3'd0, 1'b0, 2'b00, 0, 0);
    run_req(4'b1111, 3'd7, 1'b0, 2'b00, 0, 0);
    run_req(4'b1011, 3'd5, 1'b1, 2'b01, 0, 0);
    run_req(4'b1001, 3'd2, 1'b0, 2'b00, 0, 0);
    run_req(4'b1001, 3'd1, 1'b0, 2'b00, 0, 0);
    run_req(4'b0110, 3'd3, 1'b1, 2'b00, 1, 0);
    run_req(4'b1011, 3'd3, 1'b0, 2'b01, 0, 1);

    for (int i = 0; i < 40; i++)
      run_req(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
